hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Parametrised pipeline hazard controller for the 5-stage RISC-V core. It sits beside the ID stage, in place of the purely combinational load-use detector. It adds configurable multi-cycle load-use stalls and x0 exclusion. It also adds a store/load operand class, a hold for a multi-cycle divider, and taken-branch flush with priority. A saturating stall counter provides performance monitoring.

## Interface
Parameters:
- WIDTH_SOURCE, 5, register-index width
- OPCODE_6_4, 3, width of decoded opcode bits [6:4]
- LOAD_LAT, 1, bubble cycles per load-use hazard (>=1)
- DIV_MAX, 40, divider watchdog limit in cycles (>=2)
- CNT_W, 16, stall-counter width

Ports:
- CLK  in  1  clock. One clock domain; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high
- IF_ID_rs1  in  WIDTH_SOURCE  rs1 of instruction in ID
- IF_ID_rs2  in  WIDTH_SOURCE  rs2 of instruction in ID
- opcode  in  OPCODE_6_4  opcode[6:4] of instruction in ID
- ID_EX_Reg_rd  in  WIDTH_SOURCE  rd of instruction in EX
- ID_EX_MEM_Rd  in  1  instruction in EX is a load
- ID_EX_Div  in  1  instruction in EX is a div/rem
- Div_Done  in  1  divider result valid this cycle
- Branch_Taken  in  1  EX resolved a taken branch/jump
- Cnt_Clr  in  1  synchronous clear of Stall_Cnt
- PC_Stall  out  1  hold PC
- IF_ID_Stall  out  1  hold IF/ID register
- IF_ID_Flush  out  1  zero IF/ID register
- Mux_Sel_Flush  out  1  select bubble into ID/EX
- ID_EX_Stall  out  1  hold ID/EX register
- Div_Timeout  out  1  sticky watchdog flag
- Stall_Cnt  out  CNT_W  cycles with PC_Stall=1, saturating

## Operation
- Operand use by opcode class:
  - 110 branch, 011 R-type, 010 store: use rs1 and rs2.
  - 001 I-type, 000 load: use rs1 only.
  - All other classes: no operands.
- hz = ID_EX_MEM_Rd & (ID_EX_Reg_rd != 0) & ((rs1 used & rs1 == rd) | (rs2 used & rs2 == rd)).
- FSM states: IDLE, LOAD_STALL, DIV_BUSY. Counter cnt is wide enough for max(LOAD_LAT, DIV_MAX).
- IDLE, checked in priority order:
  - Branch_Taken: IF_ID_Flush=1, Mux_Sel_Flush=1, no stall; stay in IDLE. Branch overrides a simultaneous hz.
  - ID_EX_Div & !Div_Done: PC_Stall=IF_ID_Stall=ID_EX_Stall=1. Go to DIV_BUSY with cnt=1.
  - hz: PC_Stall=IF_ID_Stall=Mux_Sel_Flush=1. If LOAD_LAT>1, go to LOAD_STALL with cnt=LOAD_LAT-1; otherwise stay in IDLE.
  - Otherwise: all control outputs are 0.
- LOAD_STALL:
  - PC_Stall=IF_ID_Stall=Mux_Sel_Flush=1.
  - cnt decrements each cycle; go to IDLE on the cycle cnt==1.
  - The hazard is not re-evaluated in this state. The bubble in EX clears ID_EX_MEM_Rd.
- DIV_BUSY:
  - If Div_Done: all control outputs are 0 this cycle; go to IDLE.
  - Else if cnt==DIV_MAX-1: all control outputs are 0 this cycle; set Div_Timeout; go to IDLE.
  - Else: PC_Stall=IF_ID_Stall=ID_EX_Stall=1; cnt increments.
- A divide with Div_Done already high in IDLE causes no stall.
- Stall_Cnt: +1 on each edge where PC_Stall=1. Holds at 2^CNT_W-1. Cnt_Clr has priority over increment.
- Div_Timeout clears only on RST.

## Timing
- Control outputs are combinational from state and inputs. They are valid in the same cycle as the triggering inputs.
- Load-use: exactly LOAD_LAT stall cycles, with a bubble inserted in each; the dependent instruction leaves ID in cycle LOAD_LAT+1.
- Divide: stalls from the cycle ID_EX_Div first rises up to, but excluding, the Div_Done cycle. The maximum is DIV_MAX-1 stall cycles.
- Reset: RST high forces the FSM to IDLE and clears cnt, Stall_Cnt and Div_Timeout asynchronously. While RST=1 all outputs read 0, even if inputs signal a hazard.
- Reset mid-stall aborts the stall immediately. Operation restarts in IDLE on the first edge after RST falls.

## Test plan
- LOAD_LAT=1, load x5 in EX, opcode=011 with rs2=5 -> one cycle PC_Stall=IF_ID_Stall=Mux_Sel_Flush=1, then 0; Stall_Cnt=1.
- LOAD_LAT=3, same hazard, opcode=110 with rs1=5 -> stall for exactly 3 cycles; Stall_Cnt=3. The same stimulus with rd=0 -> no stall.
- opcode=001 with rs2=rd=7 (rs1 differs) -> no stall. opcode=010 with rs2=7 -> stall.
- ID_EX_Div=1, Div_Done pulses 10 cycles later -> 10 stall cycles with ID_EX_Stall=1 and Mux_Sel_Flush=0; outputs 0 in the Done cycle. DIV_MAX=8 without Div_Done -> 7 stall cycles, then Div_Timeout=1.
- Branch_Taken and hz in the same cycle -> IF_ID_Flush=Mux_Sel_Flush=1, PC_Stall=0; next cycle IDLE with no stall.
- RST asserted during cycle 2 of a LOAD_LAT=3 stall -> outputs 0 immediately; after release, a clean hazard gives exactly 3 stall cycles. CNT_W=2 with 5 stalls -> Stall_Cnt=3. Cnt_Clr -> 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller beside the ID stage: load-use stalls, divider hold with
// watchdog, taken-branch flush, and a saturating stall counter.
module hazard_stall_ctrl #(
  parameter int WIDTH_SOURCE = 5,
  parameter int OPCODE_6_4   = 3,
  parameter int LOAD_LAT     = 1,
  parameter int DIV_MAX      = 40,
  parameter int CNT_W        = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [WIDTH_SOURCE-1:0] IF_ID_rs1,
  input  logic [WIDTH_SOURCE-1:0] IF_ID_rs2,
  input  logic [OPCODE_6_4-1:0]   opcode,
  input  logic [WIDTH_SOURCE-1:0] ID_EX_Reg_rd,
  input  logic                    ID_EX_MEM_Rd,
  input  logic                    ID_EX_Div,
  input  logic                    Div_Done,
  input  logic                    Branch_Taken,
  input  logic                    Cnt_Clr,
  output logic                    PC_Stall,
  output logic                    IF_ID_Stall,
  output logic                    IF_ID_Flush,
  output logic                    Mux_Sel_Flush,
  output logic                    ID_EX_Stall,
  output logic                    Div_Timeout,
  output logic [CNT_W-1:0]        Stall_Cnt
);

  localparam int MAX_CNT = (LOAD_LAT > DIV_MAX) ? LOAD_LAT : DIV_MAX;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] LOAD_STALL = 2'd1;
  localparam logic [1:0] DIV_BUSY   = 2'd2;

  localparam logic [OPCODE_6_4-1:0] OP_LOAD   = OPCODE_6_4'(3'b000);
  localparam logic [OPCODE_6_4-1:0] OP_ITYPE  = OPCODE_6_4'(3'b001);
  localparam logic [OPCODE_6_4-1:0] OP_STORE  = OPCODE_6_4'(3'b010);
  localparam logic [OPCODE_6_4-1:0] OP_RTYPE  = OPCODE_6_4'(3'b011);
  localparam logic [OPCODE_6_4-1:0] OP_BRANCH = OPCODE_6_4'(3'b110);

  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          use_rs1, use_rs2, hz;
  logic          pc_stall_c, ifid_stall_c, ifid_flush_c, mux_flush_c, idex_stall_c;
  logic          timeout_set;

  // Which source registers the instruction in ID actually reads.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_BRANCH, OP_RTYPE, OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_ITYPE, OP_LOAD: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  // x0 never carries a real dependency, so rd==0 is excluded.
  assign hz = ID_EX_MEM_Rd && (ID_EX_Reg_rd != '0) &&
              ((use_rs1 && (IF_ID_rs1 == ID_EX_Reg_rd)) ||
               (use_rs2 && (IF_ID_rs2 == ID_EX_Reg_rd)));

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    pc_stall_c   = 1'b0;
    ifid_stall_c = 1'b0;
    ifid_flush_c = 1'b0;
    mux_flush_c  = 1'b0;
    idex_stall_c = 1'b0;
    timeout_set  = 1'b0;
    case (state)
      IDLE: begin
        if (Branch_Taken) begin
          ifid_flush_c = 1'b1;
          mux_flush_c  = 1'b1;
        end else if (ID_EX_Div && !Div_Done) begin
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
          idex_stall_c = 1'b1;
          state_nx     = DIV_BUSY;
          cnt_nx       = CW'(1);
        end else if (hz) begin
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
          mux_flush_c  = 1'b1;
          if (LOAD_LAT > 1) begin
            state_nx = LOAD_STALL;
            cnt_nx   = CW'(LOAD_LAT - 1);
          end
        end
      end
      LOAD_STALL: begin
        // The bubble now in EX has cleared the load flag, so hz is not rechecked.
        pc_stall_c   = 1'b1;
        ifid_stall_c = 1'b1;
        mux_flush_c  = 1'b1;
        cnt_nx       = cnt - 1'b1;
        if (cnt == CW'(1)) state_nx = IDLE;
      end
      DIV_BUSY: begin
        if (Div_Done) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CW'(DIV_MAX - 1)) begin
          timeout_set = 1'b1;
          state_nx    = IDLE;
          cnt_nx      = '0;
        end else begin
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
          idex_stall_c = 1'b1;
          cnt_nx       = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are forced low while reset is held, even with hazard inputs active.
  assign PC_Stall      = pc_stall_c   & ~RST;
  assign IF_ID_Stall   = ifid_stall_c & ~RST;
  assign IF_ID_Flush   = ifid_flush_c & ~RST;
  assign Mux_Sel_Flush = mux_flush_c  & ~RST;
  assign ID_EX_Stall   = idex_stall_c & ~RST;

  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      Div_Timeout <= 1'b0;
      Stall_Cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (timeout_set) Div_Timeout <= 1'b1;
      if (Cnt_Clr)                             Stall_Cnt <= '0;
      else if (PC_Stall && (Stall_Cnt != '1))  Stall_Cnt <= Stall_Cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: two parameterisations share one
// stimulus stream; expected control vectors go through a scoreboard queue.
module tb_hazard_stall_ctrl;

  // {PC_Stall, IF_ID_Stall, IF_ID_Flush, Mux_Sel_Flush, ID_EX_Stall}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_LOAD = 5'b11010;
  localparam logic [4:0] C_DIV  = 5'b11001;
  localparam logic [4:0] C_BR   = 5'b00110;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] op;
  logic       ld, div, done, br, clr;

  logic        a_pc, a_ifs, a_iff, a_mux, a_idex, a_to;
  logic [15:0] a_cnt;
  logic        b_pc, b_ifs, b_iff, b_mux, b_idex, b_to;
  logic [1:0]  b_cnt;
  logic [4:0]  a_ctrl, b_ctrl;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string      name;
    logic [4:0] ea;
    logic [4:0] eb;
    bit         ma;
    bit         mb;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  hazard_stall_ctrl #(.WIDTH_SOURCE(5), .OPCODE_6_4(3), .LOAD_LAT(1), .DIV_MAX(40), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST(RST), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .opcode(op),
    .ID_EX_Reg_rd(rd), .ID_EX_MEM_Rd(ld), .ID_EX_Div(div), .Div_Done(done),
    .Branch_Taken(br), .Cnt_Clr(clr), .PC_Stall(a_pc), .IF_ID_Stall(a_ifs),
    .IF_ID_Flush(a_iff), .Mux_Sel_Flush(a_mux), .ID_EX_Stall(a_idex),
    .Div_Timeout(a_to), .Stall_Cnt(a_cnt)
  );

  hazard_stall_ctrl #(.WIDTH_SOURCE(5), .OPCODE_6_4(3), .LOAD_LAT(3), .DIV_MAX(8), .CNT_W(2)) dut_b (
    .CLK(CLK), .RST(RST), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .opcode(op),
    .ID_EX_Reg_rd(rd), .ID_EX_MEM_Rd(ld), .ID_EX_Div(div), .Div_Done(done),
    .Branch_Taken(br), .Cnt_Clr(clr), .PC_Stall(b_pc), .IF_ID_Stall(b_ifs),
    .IF_ID_Flush(b_iff), .Mux_Sel_Flush(b_mux), .ID_EX_Stall(b_idex),
    .Div_Timeout(b_to), .Stall_Cnt(b_cnt)
  );

  assign a_ctrl = {a_pc, a_ifs, a_iff, a_mux, a_idex};
  assign b_ctrl = {b_pc, b_ifs, b_iff, b_mux, b_idex};

  // Scoreboard consumer: one expectation per cycle, compared mid-cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.ma) begin
        checks++;
        if (a_ctrl !== e.ea) $display("FAIL %s dut_a ctrl got=%b exp=%b t=%0t", e.name, a_ctrl, e.ea, $time);
        else passed++;
      end
      if (e.mb) begin
        checks++;
        if (b_ctrl !== e.eb) $display("FAIL %s dut_b ctrl got=%b exp=%b t=%0t", e.name, b_ctrl, e.eb, $time);
        else passed++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick(input string name, input logic [4:0] ea, input logic [4:0] eb,
                      input bit ma, input bit mb);
    exp_t e;
    e.name = name; e.ea = ea; e.eb = eb; e.ma = ma; e.mb = mb;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    rs1 = '0; rs2 = '0; rd = '0; op = 3'b111;
    ld = 0; div = 0; done = 0; br = 0; clr = 0;
  endtask

  task automatic set_hz(input logic [2:0] o, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] d);
    op = o; rs1 = r1; rs2 = r2; rd = d; ld = 1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    RST = 1;
    tick("reset_cycle", C_NONE, C_NONE, 1, 1);
    RST = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 1;
    set_hz(3'b011, 5'd1, 5'd5, 5'd5);
    tick("reset_with_hz", C_NONE, C_NONE, 1, 1);
    checks++; if (a_cnt !== 16'd0 || b_cnt !== 2'd0) $display("FAIL reset_stall_cnt got=%0d/%0d exp=0/0", a_cnt, b_cnt); else passed++;
    checks++; if (a_to !== 1'b0 || b_to !== 1'b0) $display("FAIL reset_timeout got=%b/%b exp=0/0", a_to, b_to); else passed++;
    clear_inputs();
    RST = 0;
    tick("post_reset_idle", C_NONE, C_NONE, 1, 1);
  endtask

  task automatic test_load_lat1();
    apply_reset();
    set_hz(3'b011, 5'd1, 5'd5, 5'd5);
    tick("lat1_hz", C_LOAD, C_LOAD, 1, 1);
    ld = 0;
    tick("lat1_after", C_NONE, C_LOAD, 1, 1);
    tick("lat1_after2", C_NONE, C_LOAD, 1, 1);
    tick("lat1_done", C_NONE, C_NONE, 1, 1);
    checks++; if (a_cnt !== 16'd1) $display("FAIL lat1_stall_cnt got=%0d exp=1", a_cnt); else passed++;
    checks++; if (b_cnt !== 2'd3) $display("FAIL lat3_stall_cnt_r2 got=%0d exp=3", b_cnt); else passed++;
  endtask

  task automatic test_load_lat3();
    apply_reset();
    set_hz(3'b110, 5'd5, 5'd9, 5'd5);
    for (int i = 0; i < 3; i++) tick("lat3_stall", C_NONE, C_LOAD, 0, 1);
    ld = 0;
    tick("lat3_release", C_NONE, C_NONE, 1, 1);
    checks++; if (b_cnt !== 2'd3) $display("FAIL lat3_stall_cnt got=%0d exp=3", b_cnt); else passed++;
    set_hz(3'b110, 5'd0, 5'd9, 5'd0);
    tick("rd_x0_no_hz", C_NONE, C_NONE, 1, 1);
    tick("rd_x0_no_hz2", C_NONE, C_NONE, 1, 1);
    checks++; if (b_cnt !== 2'd3) $display("FAIL x0_stall_cnt got=%0d exp=3", b_cnt); else passed++;
  endtask

  task automatic test_operand_class();
    apply_reset();
    set_hz(3'b001, 5'd3, 5'd7, 5'd7);
    tick("itype_rs2_ignored", C_NONE, C_NONE, 1, 1);
    set_hz(3'b100, 5'd7, 5'd7, 5'd7);
    tick("no_operand_class", C_NONE, C_NONE, 1, 1);
    set_hz(3'b010, 5'd3, 5'd7, 5'd7);
    tick("store_rs2_hz", C_LOAD, C_LOAD, 1, 1);
    ld = 0;
    for (int i = 0; i < 2; i++) tick("store_drain", C_NONE, C_LOAD, 1, 1);
    tick("store_idle", C_NONE, C_NONE, 1, 1);
    set_hz(3'b000, 5'd7, 5'd0, 5'd7);
    tick("load_rs1_hz", C_LOAD, C_LOAD, 1, 1);
    ld = 0;
    for (int i = 0; i < 2; i++) tick("load_drain", C_NONE, C_LOAD, 1, 1);
    tick("load_idle", C_NONE, C_NONE, 1, 1);
  endtask

  task automatic test_div_done();
    apply_reset();
    div = 1;
    for (int i = 0; i < 10; i++) tick("div_busy", C_DIV, C_NONE, 1, 0);
    done = 1;
    tick("div_done_cycle", C_NONE, C_NONE, 1, 0);
    div = 0; done = 0;
    tick("div_after", C_NONE, C_NONE, 1, 0);
    checks++; if (a_cnt !== 16'd10) $display("FAIL div_stall_cnt got=%0d exp=10", a_cnt); else passed++;
    checks++; if (a_to !== 1'b0) $display("FAIL div_no_timeout got=%b exp=0", a_to); else passed++;
  endtask

  task automatic test_div_timeout();
    apply_reset();
    div = 1;
    for (int i = 0; i < 7; i++) tick("wd_busy", C_NONE, C_DIV, 0, 1);
    checks++; if (b_to !== 1'b0) $display("FAIL wd_early got=%b exp=0", b_to); else passed++;
    tick("wd_expire_cycle", C_NONE, C_NONE, 0, 1);
    div = 0;
    checks++; if (b_to !== 1'b1) $display("FAIL wd_flag got=%b exp=1", b_to); else passed++;
    tick("wd_idle", C_NONE, C_NONE, 0, 1);
    checks++; if (b_to !== 1'b1) $display("FAIL wd_sticky got=%b exp=1", b_to); else passed++;
    checks++; if (b_cnt !== 2'd3) $display("FAIL wd_stall_cnt_sat got=%0d exp=3", b_cnt); else passed++;
    apply_reset();
    checks++; if (b_to !== 1'b0) $display("FAIL wd_reset_clear got=%b exp=0", b_to); else passed++;
  endtask

  task automatic test_div_done_in_idle();
    apply_reset();
    div = 1; done = 1;
    tick("div_done_early", C_NONE, C_NONE, 1, 1);
    clear_inputs();
    tick("div_done_early_idle", C_NONE, C_NONE, 1, 1);
    checks++; if (a_cnt !== 16'd0) $display("FAIL div_early_cnt got=%0d exp=0", a_cnt); else passed++;
  endtask

  task automatic test_branch();
    apply_reset();
    set_hz(3'b011, 5'd1, 5'd5, 5'd5);
    br = 1;
    tick("branch_over_hz", C_BR, C_BR, 1, 1);
    br = 0; ld = 0;
    tick("branch_next", C_NONE, C_NONE, 1, 1);
    checks++; if (a_cnt !== 16'd0 || b_cnt !== 2'd0) $display("FAIL branch_cnt got=%0d/%0d exp=0/0", a_cnt, b_cnt); else passed++;
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    set_hz(3'b011, 5'd1, 5'd5, 5'd5);
    tick("mid_stall_c1", C_NONE, C_LOAD, 0, 1);
    #2;
    checks++; if (b_pc !== 1'b1) $display("FAIL mid_stall_c2_active got=%b exp=1", b_pc); else passed++;
    RST = 1;
    #1;
    checks++; if (b_ctrl !== C_NONE) $display("FAIL mid_stall_abort got=%b exp=%b", b_ctrl, C_NONE); else passed++;
    checks++; if (b_cnt !== 2'd0) $display("FAIL mid_stall_cnt_clear got=%0d exp=0", b_cnt); else passed++;
    tick("mid_stall_in_reset", C_NONE, C_NONE, 1, 1);
    RST = 0;
    for (int i = 0; i < 3; i++) tick("restart_stall", C_NONE, C_LOAD, 0, 1);
    ld = 0;
    tick("restart_done", C_NONE, C_NONE, 1, 1);
    checks++; if (b_cnt !== 2'd3) $display("FAIL restart_stall_cnt got=%0d exp=3", b_cnt); else passed++;
  endtask

  task automatic test_saturation_clear();
    apply_reset();
    set_hz(3'b011, 5'd5, 5'd2, 5'd5);
    for (int i = 0; i < 5; i++) tick("sat_stall", C_LOAD, C_LOAD, 1, 1);
    checks++; if (a_cnt !== 16'd5) $display("FAIL sat_a_cnt got=%0d exp=5", a_cnt); else passed++;
    checks++; if (b_cnt !== 2'd3) $display("FAIL sat_b_cnt got=%0d exp=3", b_cnt); else passed++;
    ld = 0;
    tick("sat_drain", C_NONE, C_LOAD, 1, 1);
    checks++; if (b_cnt !== 2'd3) $display("FAIL sat_b_hold got=%0d exp=3", b_cnt); else passed++;
    ld = 1; clr = 1;
    tick("clr_during_stall", C_LOAD, C_LOAD, 1, 1);
    checks++; if (a_cnt !== 16'd0 || b_cnt !== 2'd0) $display("FAIL clr_priority got=%0d/%0d exp=0/0", a_cnt, b_cnt); else passed++;
    ld = 0; clr = 0;
    tick("clr_after", C_NONE, C_LOAD, 1, 1);
    checks++; if (a_cnt !== 16'd0) $display("FAIL clr_a_hold got=%0d exp=0", a_cnt); else passed++;
  endtask

  initial begin
    clear_inputs();
    RST = 1;
    @(posedge CLK);
    #1;
    test_reset();
    test_load_lat1();
    test_load_lat3();
    test_operand_class();
    test_div_done();
    test_div_timeout();
    test_div_done_in_idle();
    test_branch();
    test_reset_mid_stall();
    test_saturation_clear();
    @(negedge CLK);
    #1;
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
